uart_rx: RTL and testbench

//   UART receiver, 8N1, LSB first. Counterpart of our uart_tx on the same link.

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first.
// Brings the asynchronous RX line into the sys_clk domain, finds the start
// edge, samples every bit at its midpoint and hands each good byte to the
// FIFO write side with a one-cycle strobe. A low stop bit is reported as a
// framing error, and the last good byte is kept on the output.
module uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_dout,
  output logic       uart_done,
  output logic       uart_frame_err,
  output logic       uart_rx_busy
);

  // Clocks per bit and the mid-bit sample point. A BPS_CNT of at least 4 keeps
  // the sample point and the end-of-bit point on different counter values.
  localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int HALF_CNT = BPS_CNT / 2;

  localparam logic [15:0] C_BPS_LAST = 16'(BPS_CNT - 1);
  localparam logic [15:0] C_HALF     = 16'(HALF_CNT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic        r_rx_d0;
  logic        r_rx_d1;
  logic        r_rx_d2;
  logic [1:0]  r_state;
  logic [15:0] r_clk_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_dout;
  logic        r_done;
  logic        r_frame_err;

  logic        w_rx;
  logic        w_fall;
  logic        w_at_half;
  logic        w_at_last;

  // r_rx_d1 is the first stage that is treated as settled. r_rx_d2 only exists
  // so that a high-to-low step can be detected on the settled value.
  assign w_rx      = r_rx_d1;
  assign w_fall    = r_rx_d2 & ~r_rx_d1;
  assign w_at_half = (r_clk_cnt == C_HALF);
  assign w_at_last = (r_clk_cnt == C_BPS_LAST);

  assign uart_dout      = r_dout;
  assign uart_done      = r_done;
  assign uart_frame_err = r_frame_err;
  assign uart_rx_busy   = (r_state != S_IDLE);

  // Three-flop input chain; resets to the idle (high) line level so that
  // leaving reset never looks like a start edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rx_d0 <= 1'b1;
      r_rx_d1 <= 1'b1;
      r_rx_d2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value; blocking ones would collapse the chain into a wire.
      r_rx_d0 <= uart_rxd;
      r_rx_d1 <= r_rx_d0;
      r_rx_d2 <= r_rx_d1;
    end
  end

  // Frame FSM with bit-period counter, shift register and output strobes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_clk_cnt   <= 16'd0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'd0;
      r_dout      <= 8'd0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      // Strobes are single-cycle unless set again below.
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;

      // The counter runs through one bit period in every active state and is
      // held at zero while idle, so a new frame always starts from zero.
      if (r_state == S_IDLE || w_at_last) begin
        r_clk_cnt <= 16'd0;
      end else begin
        r_clk_cnt <= r_clk_cnt + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          // A line that is high again at mid start bit was only a glitch.
          if (w_at_half && w_rx) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= 16'd0;
          end else if (w_at_last) begin
            r_state   <= S_DATA;
            r_bit_cnt <= 3'd0;
          end
        end

        S_DATA: begin
          if (w_at_half) begin
            r_shift[r_bit_cnt] <= w_rx;
          end
          if (w_at_last) begin
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end

        S_STOP: begin
          // Going idle at mid stop bit leaves half a bit of slack, which
          // absorbs a shortened stop bit and back-to-back frames.
          if (w_at_half) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= 16'd0;
            if (w_rx) begin
              r_dout <= r_shift;
              r_done <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// A line driver produces whole serial frames from a byte, a stop-bit length
// and a stop-bit level. The reference model turns each frame into the event
// the receiver owes: a good stop bit means a data event carrying the byte,
// and a low stop bit means an error event with the output still showing the
// last good byte. A monitor logs the pulses the DUT produces, and the two
// event lists are compared phase by phase.
module tb_uart_rx;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int UART_BPS   = 100_000;
  localparam int B          = CLK_FREQ / UART_BPS;  // clocks per bit
  localparam int H          = B / 2;                // mid-bit point
  localparam int STOP_SHORT = B - B / 16;           // transmitter's short stop bit
  localparam int LATENCY    = 2 + 1 + 9 * B + H + 1;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic [7:0] uart_dout;
  logic       uart_done;
  logic       uart_frame_err;
  logic       uart_rx_busy;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .uart_rxd       (uart_rxd),
    .uart_dout      (uart_dout),
    .uart_done      (uart_done),
    .uart_frame_err (uart_frame_err),
    .uart_rx_busy   (uart_rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t        act_q[$];
  ev_t        exp_q[$];
  int         cyc         = 0;
  int         n_checks    = 0;
  int         n_fail      = 0;
  int         overlap     = 0;
  int         wide        = 0;
  int         busy_cycles = 0;
  logic       prev_done   = 1'b0;
  logic       prev_err    = 1'b0;
  logic [7:0] last_good   = 8'd0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: sample on the falling edge, log every pulse and its cycle.
  always @(negedge sys_clk) begin
    if (uart_done && uart_frame_err) overlap <= overlap + 1;
    if ((uart_done && prev_done) || (uart_frame_err && prev_err)) wide <= wide + 1;
    if (uart_done && !prev_done) act_q.push_back('{1'b0, uart_dout, cyc});
    if (uart_frame_err && !prev_err) act_q.push_back('{1'b1, uart_dout, cyc});
    if (uart_rx_busy) busy_cycles <= busy_cycles + 1;
    prev_done <= uart_done;
    prev_err  <= uart_frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive changes land 1 time unit after a rising edge.
  task automatic wait_clk(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Reference model: what the receiver owes for one frame.
  task automatic push_exp(input bit is_err, input logic [7:0] b);
    if (!is_err) last_good = b;
    exp_q.push_back('{is_err, last_good, 0});
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_len, input logic stop_val,
                            output int t_fall);
    t_fall   = cyc;
    uart_rxd = 1'b0;
    wait_clk(B);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_clk(B);
    end
    uart_rxd = stop_val;
    wait_clk(stop_len);
    uart_rxd = 1'b1;
    push_exp(!stop_val, b);
  endtask

  task automatic compare_events(input string tag);
    ev_t a;
    ev_t e;
    check({tag, "_count"}, act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_kind"}, a.is_err, e.is_err);
      check({tag, "_data"}, a.data, e.data);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         t_fall;
    int         lat;
    int         b0;
    int         g;
    logic [7:0] vals [256];
    logic [7:0] tmp;

    // Reset state.
    wait_clk(3);
    check("rst_dout", uart_dout, 8'h00);
    check("rst_done", uart_done, 1'b0);
    check("rst_err", uart_frame_err, 1'b0);
    check("rst_busy", uart_rx_busy, 1'b0);
    sys_rst = 1'b0;
    wait_clk(2 * B);

    // Single frame with timing check.
    send_frame(8'h55, B, 1'b1, t_fall);
    wait_clk(B);
    lat = (act_q.size() > 0) ? act_q[0].cyc - t_fall : -1;
    if (lat < LATENCY - 2 || lat > LATENCY + 2)
      $display("latency observed %0d clocks, model %0d", lat, LATENCY);
    check("f55_latency_in_window", (lat >= LATENCY - 2 && lat <= LATENCY + 2), 1);
    compare_events("f55");
    check("f55_dout", uart_dout, 8'h55);

    // Back-to-back frames with the short stop bit.
    send_frame(8'hA3, STOP_SHORT, 1'b1, t_fall);
    send_frame(8'h0F, STOP_SHORT, 1'b1, t_fall);
    wait_clk(B);
    compare_events("b2b");
    check("b2b_dout", uart_dout, 8'h0F);

    // Short low glitch on an idle line.
    b0 = busy_cycles;
    uart_rxd = 1'b0;
    wait_clk(3);
    uart_rxd = 1'b1;
    wait_clk(3 * B);
    g = busy_cycles - b0;
    check("glitch_busy_seen", g > 0, 1);
    check("glitch_busy_short", g <= H + 2, 1);
    check("glitch_busy_end", uart_rx_busy, 1'b0);
    compare_events("glitch");

    // Low stop bit: error pulse, output keeps the last good byte.
    send_frame(8'hFF, B, 1'b0, t_fall);
    wait_clk(B);
    compare_events("badstop");
    check("badstop_dout", uart_dout, 8'h0F);

    // Break: one error, then idle while the line stays low.
    uart_rxd = 1'b0;
    push_exp(1'b1, 8'h00);
    wait_clk(12 * B);
    check("break_idle_low", uart_rx_busy, 1'b0);
    wait_clk(4 * B);
    uart_rxd = 1'b1;
    wait_clk(2 * B);
    compare_events("break");
    check("break_dout", uart_dout, 8'h0F);

    // Reset in the middle of data bit 4.
    tmp = 8'hE5;
    uart_rxd = 1'b0;
    wait_clk(B);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = tmp[i];
      wait_clk(B);
    end
    uart_rxd = tmp[4];
    wait_clk(H);
    sys_rst  = 1'b1;
    uart_rxd = 1'b1;
    wait_clk(1);
    check("midrst_busy", uart_rx_busy, 1'b0);
    check("midrst_dout", uart_dout, 8'h00);
    sys_rst   = 1'b0;
    last_good = 8'h00;
    wait_clk(3 * B);
    check("midrst_idle", uart_rx_busy, 1'b0);
    compare_events("midrst");
    send_frame(8'h3C, B, 1'b1, t_fall);
    wait_clk(B);
    compare_events("after_rst");
    check("after_rst_dout", uart_dout, 8'h3C);

    // All byte values in random order, random stop length and gaps, with
    // occasional bad-stop frames mixed in.
    for (int i = 0; i < 256; i++) vals[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      j       = $urandom_range(0, i);
      tmp     = vals[i];
      vals[i] = vals[j];
      vals[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      int sl;
      if ($urandom_range(0, 7) == 0) begin
        send_frame(8'($urandom_range(0, 255)), B, 1'b0, t_fall);
        wait_clk($urandom_range(4, B));
      end
      case ($urandom_range(0, 2))
        0:       sl = STOP_SHORT;
        1:       sl = B;
        default: sl = B + $urandom_range(1, B);
      endcase
      send_frame(vals[i], sl, 1'b1, t_fall);
      wait_clk($urandom_range(0, H));
    end
    wait_clk(2 * B);
    compare_events("rand");

    check("pulse_overlap", overlap, 0);
    check("pulse_width", wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
